// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one 64-bit memory port between the instruction cache (block reads
// only) and the data cache (block reads and write-through word writes).
// Serialises requests, holds the memory strobes for MEM_LATENCY cycles, then
// returns the block (reads) or completion (writes) with a one-cycle ack.
//
// Sequence per access: IDLE (arbitrate) -> BUSY (MEM_LATENCY cycles) ->
// DONE (ack) -> IDLE. At least one IDLE cycle separates two accesses.
//
// Parameters:
//   MEM_LATENCY  memory cycles per access, 1..255 (default 7)
//   ADDR_W       address width (default 16)
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_req_read, i_address     I-cache block read request (level) and address
//   i_ack, i_rdata            I-cache completion pulse and returned block
//   d_req_read, d_req_write   D-cache read / write request (level)
//   d_address, d_wdata        D-cache address and 16-bit write word
//   d_ack, d_rdata            D-cache completion pulse and returned block
//   readM, writeM             memory read / write strobes (BUSY only)
//   mem_address               memory address (latched request address)
//   dataM                     bidirectional memory data bus
//   busy                      high while an access is in BUSY or DONE
//
// Build option:
//   ROUND_ROBIN_EN  when defined, simultaneous I/D requests alternate using a
//                   last_owner register; otherwise D always beats I.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LATENCY = 7,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_ack,
    output logic [63:0]       i_rdata,
    input  logic              d_req_read,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    output logic [63:0]       d_rdata,
    output logic              readM,
    output logic              writeM,
    output logic [ADDR_W-1:0] mem_address,
    inout  wire  [63:0]       dataM,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam logic [7:0] LATENCY_CNT = 8'(MEM_LATENCY);

    logic [1:0]        state_q,    state_d;
    logic [7:0]        count_q,    count_d;
    logic              owner_q,    owner_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [15:0]       wdata_q,    wdata_d;
    logic [63:0]       i_rdata_q,  i_rdata_d;
    logic [63:0]       d_rdata_q,  d_rdata_d;

    logic i_cand;
    logic d_cand;
    logic pick_d;

    assign i_cand = i_req_read;
    assign d_cand = d_req_read | d_req_write;

`ifdef ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On contention the requester that was not served last wins; a lone
    // requester always wins.
    assign pick_d = d_cand & (~i_cand | (last_owner_q == OWNER_I));

    always_comb begin
        last_owner_d = last_owner_q;
        if ((state_q == S_IDLE) && (i_cand | d_cand)) begin
            last_owner_d = pick_d ? OWNER_D : OWNER_I;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_q <= OWNER_I;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    // Fixed priority: a continuously requesting D-cache starves the I-cache.
    assign pick_d = d_cand;
`endif

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        owner_d    = owner_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_cand | d_cand) begin
                    state_d = S_BUSY;
                    count_d = LATENCY_CNT;
                    if (pick_d) begin
                        owner_d    = OWNER_D;
                        // A read+write request from the D-cache is a write.
                        op_write_d = d_req_write;
                        addr_d     = d_address;
                        wdata_d    = d_wdata;
                    end else begin
                        owner_d    = OWNER_I;
                        op_write_d = 1'b0;
                        addr_d     = i_address;
                    end
                end
            end
            S_BUSY: begin
                count_d = count_q - 8'd1;
                // Last memory cycle: the bus holds the block for a read.
                if (count_q == 8'd1) begin
                    state_d = S_DONE;
                    if (!op_write_q) begin
                        if (owner_q == OWNER_D) begin
                            d_rdata_d = dataM;
                        end else begin
                            i_rdata_d = dataM;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= 8'd0;
            owner_q    <= OWNER_I;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 16'd0;
            i_rdata_q  <= 64'd0;
            d_rdata_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            owner_q    <= owner_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Strobes and acks decode directly from registered state, so an async
    // reset drops them immediately and an in-flight access ends with no ack.
    assign readM       = (state_q == S_BUSY) & ~op_write_q;
    assign writeM      = (state_q == S_BUSY) &  op_write_q;
    assign busy        = (state_q != S_IDLE);
    assign i_ack       = (state_q == S_DONE) & (owner_q == OWNER_I);
    assign d_ack       = (state_q == S_DONE) & (owner_q == OWNER_D);
    assign mem_address = addr_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;

    // Only the low word is driven during a write; the upper bits never are.
    assign dataM[15:0]  = writeM ? wdata_q : 16'bz;
    assign dataM[63:16] = 48'bz;

endmodule
